// File: rtl/cache_req_sequencer_if.sv
// Request, cache-port and AXI-style response bundle
// for the cache request sequencer.
interface cache_req_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int R_WIDTH    = ADDR_WIDTH + ID_WIDTH + 13;
  localparam int W_WIDTH    = R_WIDTH + DATA_WIDTH + STRB_WIDTH;

  logic [W_WIDTH-1:0]    in_data;
  logic                  in_rw;
  logic                  in_valid;
  logic                  in_ready;

  logic                  cache_req_valid;
  logic                  cache_req_ready;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_we;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic [STRB_WIDTH-1:0] cache_wstrb;
  logic                  cache_rsp_valid;
  logic [DATA_WIDTH-1:0] cache_rsp_data;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;

  modport master (
    input  in_data, in_rw, in_valid,
    output in_ready,
    output cache_req_valid, cache_addr, cache_we,
    output cache_wdata, cache_wstrb,
    input  cache_req_ready, cache_rsp_valid,
    input  cache_rsp_data,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready,
    output b_valid, b_id, b_resp,
    input  b_ready
  );

  modport slave (
    output in_data, in_rw, in_valid,
    input  in_ready,
    input  cache_req_valid, cache_addr, cache_we,
    input  cache_wdata, cache_wstrb,
    output cache_req_ready, cache_rsp_valid,
    output cache_rsp_data,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready,
    input  b_valid, b_id, b_resp,
    output b_ready
  );
endinterface

// File: rtl/cache_req_sequencer.sv
// Sequences one arbitrated AXI request at a time
// into single-beat cache accesses and R/B responses.
module cache_req_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input logic                   clk,
  input logic                   rst,
  cache_req_sequencer_if.master bus
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int R_WIDTH = ADDR_WIDTH + ID_WIDTH + 13;
  localparam int W_WIDTH = R_WIDTH + DATA_WIDTH + STRB_W;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RBEAT, BRESP, ERR
  } state_t;

  state_t state_q, state_d;

  logic                  in_ready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            beat_cnt_q;

  logic [R_WIDTH-1:0]    hdr;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [ID_WIDTH-1:0]   h_id;
  logic [1:0]            h_burst;
  logic [2:0]            h_size;
  logic [7:0]            h_len;
  logic                  legal;
  logic                  accept;
  logic                  last;

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign hdr = bus.in_rw ? bus.in_data[W_WIDTH-1 -: R_WIDTH]
                         : bus.in_data[R_WIDTH-1:0];
  assign h_addr  = hdr[R_WIDTH-1 -: ADDR_WIDTH];
  assign h_id    = hdr[13 +: ID_WIDTH];
  assign h_burst = hdr[12:11];
  assign h_size  = hdr[10:8];
  assign h_len   = hdr[7:0];

  assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign last   = (beat_cnt_q == len_q);

  // Header legality; any violation turns into an SLVERR response
  always_comb begin
    legal = 1'b1;
    if (h_burst == 2'b11)
      legal = 1'b0;
    if (h_size > MAX_SIZE)
      legal = 1'b0;
    if (h_burst == 2'b10 &&
        !(h_len == 8'd1 || h_len == 8'd3 ||
          h_len == 8'd7 || h_len == 8'd15))
      legal = 1'b0;
    if (bus.in_rw && h_len != 8'd0)
      legal = 1'b0;
  end

  // Next beat address for FIXED / INCR / WRAP bursts
  always_comb begin
    step     = ADDR_WIDTH'(1) << size_q;
    span     = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    addr_inc = addr_q + step;
    addr_nxt = addr_q;
    unique case (1'b1)
      burst_q == 2'b01: addr_nxt = addr_inc;
      burst_q == 2'b10: addr_nxt = (addr_q & ~(span - 1'b1)) |
                                   (addr_inc & (span - 1'b1));
      default:          addr_nxt = addr_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = legal ? REQ : ERR;
      REQ:   if (bus.cache_req_ready) state_d = WAIT;
      WAIT:  if (bus.cache_rsp_valid)
               state_d = we_q ? BRESP : RBEAT;
      RBEAT: if (bus.r_ready) state_d = last ? IDLE : REQ;
      BRESP: if (bus.b_ready) state_d = IDLE;
      ERR: begin
        if (we_q) begin
          if (bus.b_ready) state_d = IDLE;
        end else if (bus.r_ready && last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counting and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        addr_q     <= h_addr;
        id_q       <= h_id;
        burst_q    <= h_burst;
        size_q     <= h_size;
        len_q      <= h_len;
        we_q       <= bus.in_rw;
        wdata_q    <= bus.in_rw ? bus.in_data[STRB_W +: DATA_WIDTH] : '0;
        wstrb_q    <= bus.in_rw ? bus.in_data[STRB_W-1:0] : '0;
        rdata_q    <= '0;
        beat_cnt_q <= '0;
      end
      if (state_q == WAIT && bus.cache_rsp_valid && !we_q)
        rdata_q <= bus.cache_rsp_data;
      if (state_q == RBEAT && bus.r_ready && !last) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        addr_q     <= addr_nxt;
      end
      if (state_q == ERR && !we_q && bus.r_ready && !last)
        beat_cnt_q <= beat_cnt_q + 8'd1;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.cache_req_valid = (state_q == REQ);
  assign bus.cache_addr      = addr_q;
  assign bus.cache_we        = we_q;
  assign bus.cache_wdata     = wdata_q;
  assign bus.cache_wstrb     = wstrb_q;

  assign bus.r_valid = (state_q == RBEAT) || (state_q == ERR && !we_q);
  assign bus.r_id    = id_q;
  assign bus.r_data  = (state_q == RBEAT) ? rdata_q : '0;
  assign bus.r_resp  = (state_q == ERR && !we_q) ? 2'b10 : 2'b00;
  assign bus.r_last  = bus.r_valid && last;

  assign bus.b_valid = (state_q == BRESP) || (state_q == ERR && we_q);
  assign bus.b_id    = id_q;
  assign bus.b_resp  = (state_q == ERR && we_q) ? 2'b10 : 2'b00;
endmodule
